// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the mem_access stage.
// Contents: bus widths, memop and FSM encodings, captured request payload,
// and small decode helpers for access size / direction / alignment.
package mem_access_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned MEMOP_W    = 4;

    typedef enum logic [MEMOP_W-1:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    // Instruction fields held for the duration of a multi-cycle access
    typedef struct packed {
        logic [MEMOP_W-1:0]    op;
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [REG_W-1:0]      sdata;
    } mem_req_t;

    // Number of bus bytes moved by an op (0 for non-memory ops)
    function automatic logic [2:0] op_size(input logic [MEMOP_W-1:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 3'd1;
            MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
            MEM_LW, MEM_SW:          return 3'd4;
            default:                 return 3'd0;
        endcase
    endfunction

    function automatic logic op_is_mem(input logic [MEMOP_W-1:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic op_is_store(input logic [MEMOP_W-1:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic op_misaligned(input logic [MEMOP_W-1:0] op,
                                           input logic [1:0]         a);
        return ((op_size(op) == 3'd2) && a[0]) ||
               ((op_size(op) == 3'd4) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Sign/zero extension of assembled load bytes according to the memop.
// Ports: memop (load kind), bytes (little-endian assembled data),
//        result (write-back value).
module mem_access_load_ext
    import mem_access_pkg::*;
(
    input  logic [MEMOP_W-1:0] memop,
    input  logic [REG_W-1:0]   bytes,
    output logic [REG_W-1:0]   result
);

    // Extend from the access width; LW and anything else pass unchanged
    always_comb begin
        result = bytes;
        case (memop)
            MEM_LB:  result = {{24{bytes[7]}},  bytes[7:0]};
            MEM_LH:  result = {{16{bytes[15]}}, bytes[15:0]};
            MEM_LBU: result = {24'd0, bytes[7:0]};
            MEM_LHU: result = {16'd0, bytes[15:0]};
            default: result = bytes;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results to write-back and runs
// byte-serial loads/stores over a shared 8-bit bus, stalling upstream until
// the access completes.
// Ports: clk, rst (async active-low); EX/MEM inputs valid_i, memop_i, wd_i,
//        wreg_i, wdata_i, mem_addr_i, store_data_i; bus mem_gnt_i, mem_din_i,
//        mem_req_o, mem_a_o, mem_dout_o, mem_wr_o; write-back wd_o, wreg_o,
//        wdata_o, valid_o; stall_req_o; err_o.
// Build option: define MEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses with err_o instead of performing them byte-serially.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [MEMOP_W-1:0]    memop_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      wdata_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [REG_W-1:0]      store_data_i,
    input  logic                  mem_gnt_i,
    input  logic [7:0]            mem_din_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  valid_o,
    output logic                  stall_req_o,
    output logic                  mem_req_o,
    output logic [MEM_ADDR_W-1:0] mem_a_o,
    output logic [7:0]            mem_dout_o,
    output logic                  mem_wr_o,
    output logic                  err_o
);

    state_e                state;
    mem_req_t              req;
    logic [MEM_ADDR_W-1:0] addr;
    logic [2:0]            size;
    logic [2:0]            k;
    logic [REG_W-1:0]      ldata;
    logic                  rd_pend;

    logic                  is_store;
    logic                  last_byte;
    logic                  start;
    logic                  misalign;
    logic [1:0]            lane;
    logic [REG_W-1:0]      ld_bytes;
    logic [REG_W-1:0]      ld_result;

    assign is_store  = op_is_store(req.op);
    assign last_byte = (k == size - 3'd1);
    assign start     = valid_i && op_is_mem(memop_i);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = op_misaligned(memop_i, mem_addr_i[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // Read data for byte k-1 arrives the cycle after its grant; merge it in
    assign lane = 2'(k - 3'd1);
    always_comb begin
        ld_bytes = ldata;
        if (rd_pend) begin
            ld_bytes[{lane, 3'b000} +: 8] = mem_din_i;
        end
    end

    mem_access_load_ext u_load_ext (
        .memop  (req.op),
        .bytes  (ld_bytes),
        .result (ld_result)
    );

    // Bus outputs decode from state flops only, so reset clears them at once
    assign mem_req_o  = (state == ST_ACCESS);
    assign mem_wr_o   = mem_req_o && is_store;
    assign mem_a_o    = mem_req_o ? addr + MEM_ADDR_W'(k) : '0;
    assign mem_dout_o = mem_req_o ? req.sdata[{k[1:0], 3'b000} +: 8] : 8'd0;

    // Upstream must hold from the capture cycle; released in the completion cycle
    assign stall_req_o = rst &&
        (((state == ST_IDLE) && start && !misalign) ||
         ((state == ST_ACCESS) && !(is_store && mem_gnt_i && last_byte)));

    // Stage FSM and registered write-back outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            req     <= '0;
            addr    <= '0;
            size    <= 3'd0;
            k       <= 3'd0;
            ldata   <= '0;
            rd_pend <= 1'b0;
            wd_o    <= '0;
            wreg_o  <= 1'b0;
            wdata_o <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            rd_pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        if (!op_is_mem(memop_i)) begin
                            wd_o    <= wd_i;
                            wreg_o  <= wreg_i;
                            wdata_o <= wdata_i;
                            valid_o <= 1'b1;
                        end else if (misalign) begin
                            wd_o    <= wd_i;
                            wreg_o  <= 1'b0;
                            wdata_o <= '0;
                            valid_o <= 1'b1;
                            err_o   <= 1'b1;
                        end else begin
                            req   <= '{op: memop_i, wd: wd_i, wreg: wreg_i,
                                       sdata: store_data_i};
                            addr  <= mem_addr_i[MEM_ADDR_W-1:0];
                            size  <= op_size(memop_i);
                            k     <= 3'd0;
                            ldata <= '0;
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (rd_pend) begin
                        ldata <= ld_bytes;
                    end
                    if (mem_gnt_i) begin
                        k       <= k + 3'd1;
                        rd_pend <= !is_store;
                        if (last_byte) begin
                            if (is_store) begin
                                wd_o    <= req.wd;
                                wreg_o  <= 1'b0;
                                wdata_o <= '0;
                                valid_o <= 1'b1;
                                state   <= ST_IDLE;
                            end else begin
                                state <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    wd_o    <= req.wd;
                    wreg_o  <= req.wreg;
                    wdata_o <= ld_result;
                    valid_o <= 1'b1;
                    k       <= 3'd0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized ops and
// grants, compared against a transaction-level model with its own memory.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int unsigned AW = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [3:0]  memop_i = 4'd0;
    logic [4:0]  wd_i = 5'd0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = 32'd0;
    logic [31:0] mem_addr_i = 32'd0;
    logic [31:0] store_data_i = 32'd0;
    logic        mem_gnt_i = 1'b0;
    logic [7:0]  mem_din_i = 8'd0;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        valid_o;
    logic        stall_req_o;
    logic        mem_req_o;
    logic [AW-1:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic        mem_wr_o;
    logic        err_o;

    mem_access #(.MEM_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .memop_i(memop_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
        .mem_gnt_i(mem_gnt_i), .mem_din_i(mem_din_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .valid_o(valid_o),
        .stall_req_o(stall_req_o), .mem_req_o(mem_req_o), .mem_a_o(mem_a_o),
        .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus slave memory and independent model memory
    logic [7:0] mem     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_byte(a);
    endfunction

    // Slave samples the bus mid-cycle and acts on the following edge
    logic        s_req = 1'b0;
    logic        s_wr = 1'b0;
    logic [31:0] s_a = 32'd0;
    logic [7:0]  s_d = 8'd0;
    always @(negedge clk) begin
        s_req = mem_req_o & mem_gnt_i;
        s_wr  = mem_wr_o;
        s_a   = 32'(mem_a_o);
        s_d   = mem_dout_o;
    end
    always @(posedge clk) begin
        if (s_req && s_wr) mem[s_a] = s_d;
        if (s_req && !s_wr) mem_din_i <= rd_mem(s_a);
        else                mem_din_i <= 8'($urandom);
    end

    function automatic logic gnt_val(input bit rnd, input int drop, input int c);
        if (c == drop) return 1'b0;
        if (rnd) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    // Present one instruction (called just after a rising edge) and check it to completion
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] wd, input logic wr_en, input logic [31:0] wdat,
                         input bit rnd_gnt, input int drop);
        int n, issued, low, cyc, lat;
        bit is_mem, is_st, err, done, exp_stall, stall_now;
        logic [31:0] exp_data;
        logic exp_wreg;
        is_mem = (op >= 1) && (op <= 8);
        is_st  = (op == 6) || (op == 7) || (op == 8);
        n = (op == 1 || op == 4 || op == 6) ? 1 :
            (op == 2 || op == 5 || op == 7) ? 2 :
            (op == 3 || op == 8) ? 4 : 0;
        err = 0;
`ifdef MEM_ALIGN_CHECK_EN
        if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) err = 1;
`endif
        if (err) n = 0;
        exp_data = 32'd0;
        exp_wreg = 1'b0;
        if (!is_mem) begin
            exp_data = wdat;
            exp_wreg = wr_en;
        end else if (!err && !is_st) begin
            for (int i = 0; i < n; i++) exp_data |= 32'(rd_ref(a + 32'(i))) << (8 * i);
            if (op == 1 && exp_data[7])  exp_data |= 32'hFFFF_FF00;
            if (op == 2 && exp_data[15]) exp_data |= 32'hFFFF_0000;
            exp_wreg = wr_en;
        end
        if (is_st) for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = sd[8*i +: 8];

        memop_i = op; mem_addr_i = a; store_data_i = sd;
        wd_i = wd; wreg_i = wr_en; wdata_i = wdat; valid_i = 1'b1;
        mem_gnt_i = gnt_val(rnd_gnt, drop, 0);
        issued = 0; low = 0; cyc = 0; done = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            if (!is_mem || err)  exp_stall = 0;
            else if (cyc == 0)   exp_stall = 1;
            else if (issued < n) exp_stall = !(is_st && mem_gnt_i && issued == n - 1);
            else                 exp_stall = 0;
            check("stall", 32'(stall_req_o), 32'(exp_stall));
            check("req", 32'(mem_req_o), 32'(cyc > 0 && issued < n));
            if (cyc > 0 && issued < n) begin
                if (mem_gnt_i) begin
                    check("addr", 32'(mem_a_o), a + 32'(issued));
                    check("wr", 32'(mem_wr_o), 32'(is_st));
                    if (is_st) check("dout", 32'(mem_dout_o), 32'(sd[8*issued +: 8]));
                    issued++;
                end else begin
                    low++;
                end
            end
            lat = (!is_mem || err) ? 1 : (is_st ? n + low + 1 : n + low + 2);
            check("valid", 32'(valid_o), 32'(issued == n && cyc == lat));
            if (issued == n && cyc >= lat) begin
                check("wdata", wdata_o, exp_data);
                check("wreg", 32'(wreg_o), 32'(exp_wreg));
                check("wd", 32'(wd_o), 32'(wd));
                check("err", 32'(err_o), 32'(err));
                done = 1;
            end
            stall_now = stall_req_o;
            @(posedge clk); #1;
            if (!stall_now) valid_i = 1'b0;
            cyc++;
            mem_gnt_i = gnt_val(rnd_gnt, drop, cyc);
        end
        if (!done) check("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_stall", 32'(stall_req_o), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        do_op(4'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 0, -1);
        do_op(4'd8, 32'h100, 32'h1234_5678, 5'd1, 1'b1, 32'h0, 0, -1);
        do_op(4'd3, 32'h100, 32'h0, 5'd7, 1'b1, 32'h0, 0, -1);
        do_op(4'd6, 32'h200, 32'h0000_0080, 5'd2, 1'b1, 32'h0, 0, -1);
        do_op(4'd1, 32'h200, 32'h0, 5'd3, 1'b1, 32'h0, 0, -1);
        do_op(4'd4, 32'h200, 32'h0, 5'd4, 1'b1, 32'h0, 0, -1);
        do_op(4'd7, 32'h10, 32'hAABB_CCDD, 5'd6, 1'b1, 32'h0, 0, 2);
        do_op(4'd5, 32'h10, 32'h0, 5'd8, 1'b1, 32'h0, 0, -1);
        do_op(4'd2, 32'h10, 32'h0, 5'd9, 1'b1, 32'h0, 0, -1);

        // Reset in the middle of an LW: everything clears, no result emerges
        memop_i = 4'd3; mem_addr_i = 32'h300; valid_i = 1'b1; mem_gnt_i = 1'b1;
        wd_i = 5'd11; wreg_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_req_o), 32'd0);
        check("mid_rst_wr", 32'(mem_wr_o), 32'd0);
        check("mid_rst_stall", 32'(stall_req_o), 32'd0);
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_wdata", wdata_o, 32'd0);
        check("mid_rst_wd", 32'(wd_o), 32'd0);
        check("mid_rst_wreg", 32'(wreg_o), 32'd0);
        check("mid_rst_a", 32'(mem_a_o), 32'd0);
        valid_i = 1'b0;
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(valid_o), 32'd0);
        end
        @(posedge clk); #1;
        do_op(4'd3, 32'h100, 32'h0, 5'd12, 1'b1, 32'h0, 0, -1);

        // Misaligned word and address wrap
        do_op(4'd3, 32'h102, 32'h0, 5'd13, 1'b1, 32'h0, 0, -1);
        do_op(4'd8, 32'hFFFF_FFFE, 32'hCAFE_F00D, 5'd14, 1'b1, 32'h0, 0, -1);
        do_op(4'd3, 32'hFFFF_FFFE, 32'h0, 5'd15, 1'b1, 32'h0, 1, -1);

        for (int t = 0; t < 200; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                            : 32'h400 + 32'($urandom_range(0, 31));
            do_op(4'($urandom_range(0, 8)), a, $urandom, 5'($urandom), 1'($urandom),
                  $urandom, 1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the RISC-V pipeline, directly downstream of `ex` (via the EX/MEM latch). It passes ALU results through to write-back. It also executes LB/LH/LW/LBU/LHU/SB/SH/SW over the shared byte-wide memory bus as a multi-cycle FSM, holding the pipeline with a stall request until the access completes.

## Interface
- `MEM_ADDR_W`, default 32: width of memory bus address; low bits of the 32-bit effective address are used.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  EX/MEM latch holds a valid instruction.
- `memop_i`  in  `MemOpBus`(4)  NONE, LB, LH, LW, LBU, LHU, SB, SH, SW.
- `wd_i`  in  `RegAddrBus`  destination register.
- `wreg_i`  in  1  write-back enable.
- `wdata_i`  in  `RegBus`  ALU result (non-memory ops).
- `mem_addr_i`  in  32  effective address (loads/stores).
- `store_data_i`  in  `RegBus`  rs2 value for stores.
- `mem_gnt_i`  in  1  bus granted to this stage this cycle.
- `mem_din_i`  in  8  read byte, valid 1 cycle after its address was issued.
- `wd_o`  out  `RegAddrBus`  registered destination.
- `wreg_o`  out  1  registered write enable.
- `wdata_o`  out  `RegBus`  registered result / load data.
- `valid_o`  out  1  outputs valid this cycle.
- `stall_req_o`  out  1  hold EX/MEM latch and everything upstream.
- `mem_req_o`  out  1  request bus.
- `mem_a_o`  out  `MEM_ADDR_W`  byte address.
- `mem_dout_o`  out  8  write byte.
- `mem_wr_o`  out  1  1 = write, 0 = read; qualified by `mem_req_o & mem_gnt_i`.
- `err_o`  out  1  misaligned access flagged (see Configuration).

## Operation
- States: IDLE, ACCESS, DRAIN.
- IDLE, valid_i, memop NONE:
  - Register wd/wreg/wdata; valid_o=1 next cycle.
  - No stall.
- IDLE, valid_i, mem op:
  - Capture address, store data and size N (1/2/4 bytes); byte counter k=0.
  - Go to ACCESS; stall_req_o=1.
- ACCESS:
  - mem_req_o=1, mem_a_o=addr+k, mem_dout_o=store_data byte k (little-endian).
  - k advances only when mem_gnt_i=1.
  - Store: after byte N-1 is granted, return to IDLE.
  - Load: after byte N-1 is granted, go to DRAIN.
- Load bytes: mem_din_i is captured into byte lane k-1 in the cycle after each granted read.
- DRAIN: capture the last byte, then return to IDLE.
- Load result: LB/LH sign-extend; LBU/LHU zero-extend; LW unmodified.
- Stores: wreg_o forced 0; wdata_o=0.
- stall_req_o: high from the capture cycle until the completion cycle. It is low in the completion cycle (last granted store byte, or DRAIN), so upstream advances on that edge.
- Grant dropped while a read is outstanding: the byte still returns the next cycle and is captured.
- Address wrap: addr+k wraps modulo 2^MEM_ADDR_W.

## Timing
- Reset values: all outputs 0, state IDLE, k=0. Reset mid-access aborts immediately; mem_req_o/mem_wr_o drop asynchronously and no partial result is emitted.
- Non-memory op: latency 1.
- LW with constant grant: capture c0, issue c1–c4, DRAIN c5, valid_o c6. stall_req_o high c0–c4.
- SW with constant grant: issue c1–c4, valid_o c5. stall_req_o high c0–c3.
- Byte/half accesses scale by N.
- Each grant-low cycle adds one cycle.
- valid_o is a 1-cycle pulse.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Halfword with addr[0]≠0, or word with addr[1:0]≠0, performs no bus access.
  - Completes in 1 cycle with err_o=1 for one cycle, wreg_o=0, valid_o=1.
- `MEM_ALIGN_CHECK_EN` undefined:
  - Misaligned accesses proceed byte-serially exactly like aligned ones.
  - err_o tied 0.

## Structure
- `defines.v` gains:
  - `MemOpBus`
  - MEM_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW encodings
  - state encodings
- Optional sub-module `load_ext`: combinational sign/zero extension of assembled bytes by memop.

## Test plan
- ALU passthrough: memop NONE, wdata_i=0x1234, wd_i=5 → next cycle valid_o=1, wdata_o=0x1234, wd_o=5; no stall.
- LW addr 0x100, memory bytes 0x78,0x56,0x34,0x12, constant grant → addresses 0x100–0x103 issued c1–c4; wdata_o=0x12345678 at c6.
- LB at addr 0x200 holding 0x80 → wdata_o=0xFFFFFF80; LBU → 0x00000080.
- SH store_data 0xAABBCCDD to 0x10 with grant low in c2 → writes 0xDD@0x10 (c1), 0xCC@0x11 (c3); wreg_o=0.
- rst low during c2 of an LW → all outputs 0 immediately; after release, the next op completes normally.
- LW at 0x102:
  - with macro: err_o=1 and no mem_req_o.
  - without macro: bytes 0x102–0x105 read.
